// File: rtl/loader_pkg.sv
// Shared types and index decode for the download loader.
package loader_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LOAD  = 3'd1,
        ST_DRAIN = 3'd2,
        ST_FIXUP = 3'd3,
        ST_DONE  = 3'd4
    } loader_state_e;

    localparam logic [7:0] IDX_ROM    = 8'h00;
    localparam logic [5:0] IDX_PRG_LO = 6'h01;

    function automatic logic is_rom(input logic [7:0] idx);
        return idx == IDX_ROM;
    endfunction

    // 8'h01 and 8'h41 (and any index with these low bits) are PRG images.
    function automatic logic is_prg(input logic [7:0] idx);
        return idx[5:0] == IDX_PRG_LO;
    endfunction

endpackage

// File: rtl/loader_fifo.sv
// Small synchronous FIFO buffering {address, data} write requests.
// A push into a full FIFO is accepted when a pop happens in the same cycle.
module loader_fifo #(
    parameter int W     = 33,
    parameter int DEPTH = 4
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic                      push,
    input  logic [W-1:0]              din,
    input  logic                      pop,
    output logic [W-1:0]              dout,
    output logic                      full,
    output logic                      empty,
    output logic [$clog2(DEPTH):0]    count
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   cnt;
    logic          do_pop;
    logic          do_push;

    assign do_pop  = pop && (cnt != '0);
    assign do_push = push && ((cnt != FULL_CNT) || do_pop);
    assign dout    = mem[rd_ptr];
    assign full    = (cnt == FULL_CNT);
    assign empty   = (cnt == '0);
    assign count   = cnt;

    // Storage, pointers and occupancy; storage is cleared so the head reads 0 after reset.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= din;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            cnt <= cnt + (AW+1)'(do_push) - (AW+1)'(do_pop);
        end
    end

endmodule

// File: rtl/download_loader.sv
// Streams data_io download bytes into memory through a write FIFO and, for
// PRG images, patches the end-of-program pointer once the image has landed.
// mem_wr/mem_ack is a valid/ready pair: a request is transferred on a cycle
// where both are high, and address/data stay frozen while mem_wr waits.
module download_loader
    import loader_pkg::*;
#(
    parameter int                ADDR_W     = 25,
    parameter int                PTR_BYTES  = 2,
    parameter int                FIFO_DEPTH = 4,
    parameter logic [ADDR_W-1:0] ROM_BASE   = '0,
    parameter logic [ADDR_W-1:0] PRG_BASE   = 25'h18995,
    parameter logic [15:0]       PRG_ORG    = 16'h8995,
    parameter logic [ADDR_W-1:0] PTR_ADDR   = 25'h103E9
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                ioctl_download,
    input  logic [7:0]          ioctl_index,
    input  logic                ioctl_wr,
    input  logic [ADDR_W-1:0]   ioctl_addr,
    input  logic [7:0]          ioctl_dout,
    output logic                mem_wr,
    input  logic                mem_ack,
    output logic [ADDR_W-1:0]   mem_addr,
    output logic [7:0]          mem_data,
    output logic                downloading,
    output logic                rom_done,
    output logic                overflow,
    output loader_state_e       state_dbg
);

    localparam int FW = ADDR_W + 8;
    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    loader_state_e state_q, state_d;
    logic [7:0]    cur_type_q;
    logic [31:0]   len_q;
    logic          pend_q;
    logic [7:0]    pend_type_q;
    logic [31:0]   pend_len_q;
    logic [CW-1:0] pend_cnt_q;
    logic [2:0]    fix_k_q;
    logic          rom_done_q;
    logic          overflow_q;

    logic              in_load;
    logic [7:0]        strobe_type;
    logic              strobe_ok;
    logic [ADDR_W-1:0] strobe_base;
    logic [FW-1:0]     push_word;
    logic              pushed;
    logic              drop;
    logic [31:0]       cand_eff;
    logic [FW-1:0]     fifo_dout;
    logic              fifo_full;
    logic              fifo_empty;
    logic [CW-1:0]     fifo_count;
    logic [CW-1:0]     old_left;
    logic              fifo_req;
    logic              fifo_pop;
    logic [31:0]       ptr_val;
    logic [31:0]       ptr_shift;
    logic              last_fix;
    logic              enter_load;
    logic [7:0]        new_type;

    // Strobes belong to the current load in LOAD; outside it they start the next one.
    assign in_load     = (state_q == ST_LOAD);
    assign strobe_type = in_load ? cur_type_q : ioctl_index;
    assign strobe_ok   = ioctl_wr && (in_load || ioctl_download) &&
                         (is_rom(strobe_type) || is_prg(strobe_type));
    assign strobe_base = is_rom(strobe_type) ? ROM_BASE : PRG_BASE;
    assign push_word   = {strobe_base + ioctl_addr, ioctl_dout};

    // Entries queued behind the current load must not reach memory before its fixup.
    assign old_left = fifo_count - pend_cnt_q;
    assign fifo_req = (state_q == ST_FIXUP) ? 1'b0 :
                      (state_q == ST_DRAIN) ? (old_left != '0) : !fifo_empty;
    assign fifo_pop = fifo_req && mem_ack;
    assign pushed   = strobe_ok && (!fifo_full || fifo_pop);
    assign drop     = strobe_ok && fifo_full && !fifo_pop;
    assign cand_eff = pushed ? (32'(ioctl_addr) + 32'd1) : 32'd0;

    assign ptr_val   = 32'(PRG_ORG) + len_q;
    assign ptr_shift = ptr_val >> {fix_k_q, 3'b000};
    assign last_fix  = (fix_k_q == 3'(PTR_BYTES - 1));

    assign mem_wr      = (state_q == ST_FIXUP) ? 1'b1 : fifo_req;
    assign mem_addr    = (state_q == ST_FIXUP) ? (PTR_ADDR + ADDR_W'(fix_k_q)) : fifo_dout[FW-1:8];
    assign mem_data    = (state_q == ST_FIXUP) ? ptr_shift[7:0] : fifo_dout[7:0];
    assign downloading = (state_q == ST_LOAD) || (state_q == ST_DRAIN) || (state_q == ST_FIXUP);
    assign rom_done    = rom_done_q;
    assign overflow    = overflow_q;
    assign state_dbg   = state_q;

    assign enter_load = (state_d == ST_LOAD) && (state_q != ST_LOAD);
    assign new_type   = (state_q == ST_DONE && !ioctl_download) ? pend_type_q : ioctl_index;

    loader_fifo #(
        .W     (FW),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset_n (reset_n),
        .push    (pushed),
        .din     (push_word),
        .pop     (fifo_pop),
        .dout    (fifo_dout),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .count   (fifo_count)
    );

    // Next-state decode.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (ioctl_download) state_d = ST_LOAD;
            ST_LOAD:  if (!ioctl_download) state_d = ST_DRAIN;
            ST_DRAIN: if (old_left == '0) state_d = is_prg(cur_type_q) ? ST_FIXUP : ST_DONE;
            ST_FIXUP: if (mem_ack && last_fix) state_d = ST_DONE;
            ST_DONE:  state_d = (ioctl_download || pend_q) ? ST_LOAD : ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    // State register, length tracking, pending-load bookkeeping and sticky flags.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= ST_IDLE;
            cur_type_q  <= '0;
            len_q       <= '0;
            pend_q      <= 1'b0;
            pend_type_q <= '0;
            pend_len_q  <= '0;
            pend_cnt_q  <= '0;
            fix_k_q     <= '0;
            rom_done_q  <= 1'b0;
            overflow_q  <= 1'b0;
        end else begin
            state_q <= state_d;

            if (enter_load) begin
                cur_type_q <= new_type;
                len_q      <= (cand_eff > pend_len_q) ? cand_eff : pend_len_q;
            end else if (in_load && (cand_eff > len_q)) begin
                len_q <= cand_eff;
            end

            if (in_load) begin
                pend_q     <= 1'b0;
                pend_len_q <= '0;
                pend_cnt_q <= '0;
            end else begin
                if (ioctl_download) pend_type_q <= ioctl_index;
                if (ioctl_download && (state_q == ST_DRAIN || state_q == ST_FIXUP)) pend_q <= 1'b1;
                if (cand_eff > pend_len_q) pend_len_q <= cand_eff;
                pend_cnt_q <= pend_cnt_q + CW'(pushed);
            end

            if (state_q != ST_FIXUP) begin
                fix_k_q <= '0;
            end else if (mem_ack) begin
                fix_k_q <= last_fix ? 3'd0 : fix_k_q + 3'd1;
            end

            if (state_q == ST_DONE && is_rom(cur_type_q)) rom_done_q <= 1'b1;
            if (drop) overflow_q <= 1'b1;
        end
    end

endmodule

// File: tb/tb_download_loader.sv
// Scoreboarded bench for download_loader: a stimulus process pushes the
// expected memory writes, a monitor pops them as the DUT hands them over.
module tb_download_loader;
  import loader_pkg::*;

  localparam int          ADDR_W   = 25;
  localparam logic [24:0] ROM_BASE = 25'h0;
  localparam logic [24:0] PRG_BASE = 25'h18995;
  localparam logic [15:0] PRG_ORG  = 16'h8995;
  localparam logic [24:0] PTR_ADDR = 25'h103E9;
  localparam int          PTR_BYTES = 2;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          ioctl_download = 1'b0;
  logic [7:0]    ioctl_index = 8'h00;
  logic          ioctl_wr = 1'b0;
  logic [24:0]   ioctl_addr = '0;
  logic [7:0]    ioctl_dout = '0;
  logic          mem_wr;
  logic          mem_ack = 1'b1;
  logic [24:0]   mem_addr;
  logic [7:0]    mem_data;
  logic          downloading;
  logic          rom_done;
  logic          overflow;
  loader_state_e state_dbg;

  logic [32:0] exp_q[$];
  int          tests = 0;
  int          fails = 0;
  int          ack_mode = 0;   // 0: always ready, 1: random single-cycle stalls, 2: held off
  logic        ptr0_seen = 1'b0;
  logic        rom_exp = 1'b0;
  logic        ovf_exp = 1'b0;

  logic [24:0] t_offs [16];
  logic [7:0]  t_dats [16];

  download_loader #(
    .ADDR_W     (ADDR_W),
    .PTR_BYTES  (PTR_BYTES),
    .FIFO_DEPTH (4),
    .ROM_BASE   (ROM_BASE),
    .PRG_BASE   (PRG_BASE),
    .PRG_ORG    (PRG_ORG),
    .PTR_ADDR   (PTR_ADDR)
  ) dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .ioctl_download (ioctl_download),
    .ioctl_index    (ioctl_index),
    .ioctl_wr       (ioctl_wr),
    .ioctl_addr     (ioctl_addr),
    .ioctl_dout     (ioctl_dout),
    .mem_wr         (mem_wr),
    .mem_ack        (mem_ack),
    .mem_addr       (mem_addr),
    .mem_data       (mem_data),
    .downloading    (downloading),
    .rom_done       (rom_done),
    .overflow       (overflow),
    .state_dbg      (state_dbg)
  );

  // clock
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [32:0] act, input logic [32:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // memory-side ready driver
  initial begin
    logic low_prev;
    low_prev = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      case (ack_mode)
        0: mem_ack = 1'b1;
        1: mem_ack = low_prev ? 1'b1 : 1'($urandom_range(0, 1));
        default: mem_ack = 1'b0;
      endcase
      low_prev = !mem_ack;
    end
  end

  // monitor: pops the scoreboard on every transfer, checks held requests stay frozen
  initial begin
    logic        stall_prev;
    logic [32:0] held;
    logic [32:0] e;
    stall_prev = 1'b0;
    held = '0;
    forever begin
      @(negedge clk);
      if (!reset_n) begin
        stall_prev = 1'b0;
      end else begin
        if (stall_prev) begin
          check("held_request", {mem_wr, mem_addr, mem_data}, {1'b1, held[32:0]} );
        end
        if (mem_wr && mem_ack) begin
          if (exp_q.size() == 0) begin
            check("unexpected_write", {mem_addr, mem_data}, 33'h1FFFFFFFF);
          end else begin
            e = exp_q.pop_front();
            check("mem_write", {mem_addr, mem_data}, e);
            if (mem_addr == PTR_ADDR) ptr0_seen = 1'b1;
          end
        end
        stall_prev = mem_wr && !mem_ack;
        held = {mem_addr, mem_data};
      end
    end
  end

  // Issue one download of n strobes from t_offs/t_dats; only the first
  // accept_lim strobes are expected to land in memory.
  task automatic run_download(input logic [7:0] idx, input int n, input int gap_min,
                              input int gap_max, input int accept_lim);
    logic        is_r;
    logic        is_p;
    logic [31:0] len;
    logic [31:0] a32;
    logic [31:0] ptr;
    logic [24:0] base;
    logic        done;
    is_r = (idx == 8'h00);
    is_p = (idx[5:0] == 6'h01);
    base = is_r ? ROM_BASE : PRG_BASE;
    len  = 32'd0;
    @(posedge clk);
    #1;
    ioctl_download = 1'b1;
    ioctl_index    = idx;
    @(posedge clk);
    #1;
    check("downloading_up", 33'(downloading), 33'd1);
    for (int i = 0; i < n; i++) begin
      ioctl_wr   = 1'b1;
      ioctl_addr = t_offs[i];
      ioctl_dout = t_dats[i];
      if ((is_r || is_p) && i < accept_lim) begin
        a32 = 32'(base) + 32'(t_offs[i]);
        exp_q.push_back({a32[24:0], t_dats[i]});
        if (32'(t_offs[i]) + 32'd1 > len) len = 32'(t_offs[i]) + 32'd1;
      end
      @(posedge clk);
      #1;
      ioctl_wr = 1'b0;
      repeat ($urandom_range(gap_min, gap_max)) begin
        @(posedge clk);
        #1;
      end
    end
    ioctl_download = 1'b0;
    if (is_p) begin
      ptr = 32'(PRG_ORG) + len;
      for (int k = 0; k < PTR_BYTES; k++) begin
        a32 = 32'(PTR_ADDR) + 32'(k);
        exp_q.push_back({a32[24:0], ptr[8*k +: 8]});
      end
    end
    if (is_r) rom_exp = 1'b1;
    done = 1'b0;
    for (int c = 0; c < 400; c++) begin
      @(negedge clk);
      if (!downloading && exp_q.size() == 0) begin
        done = 1'b1;
        break;
      end
    end
    check("download_complete", 33'(done), 33'd1);
    exp_q.delete();
    repeat (2) @(negedge clk);
    check("downloading_down", 33'(downloading), 33'd0);
    check("rom_done", 33'(rom_done), 33'(rom_exp));
    check("overflow", 33'(overflow), 33'(ovf_exp));
  endtask

  // stimulus and final report
  initial begin
    logic [7:0] idx_pool [6];
    logic       got;
    idx_pool = '{8'h00, 8'h01, 8'h41, 8'h07, 8'h81, 8'h02};

    #1;
    check("reset_mem_wr", 33'(mem_wr), 33'd0);
    check("reset_downloading", 33'(downloading), 33'd0);
    check("reset_rom_done", 33'(rom_done), 33'd0);
    check("reset_overflow", 33'(overflow), 33'd0);
    check("reset_mem_bus", {mem_addr, mem_data}, 33'd0);
    check("reset_state", 33'(state_dbg), 33'(ST_IDLE));
    repeat (3) @(negedge clk);
    reset_n = 1'b1;

    // ignored index: no writes, rom_done untouched
    for (int i = 0; i < 3; i++) begin t_offs[i] = 25'(i); t_dats[i] = 8'($urandom); end
    run_download(8'h07, 3, 1, 2, 3);

    // ROM image at offsets 0..2
    for (int i = 0; i < 3; i++) begin t_offs[i] = 25'(i); t_dats[i] = 8'($urandom); end
    run_download(8'h00, 3, 0, 1, 3);

    // PRG 16 bytes, pointer 16'h89A5
    for (int i = 0; i < 16; i++) begin t_offs[i] = 25'(i); t_dats[i] = 8'($urandom); end
    run_download(8'h01, 16, 0, 1, 16);

    // PRG via 8'h41 with out-of-order offsets, pointer 16'h899B
    t_offs[0] = 25'd5; t_offs[1] = 25'd0; t_offs[2] = 25'd3;
    for (int i = 0; i < 3; i++) t_dats[i] = 8'($urandom);
    run_download(8'h41, 3, 1, 3, 3);

    // PRG with no bytes: pointer PRG_ORG
    run_download(8'h01, 0, 0, 0, 0);

    // address wrap past 2^ADDR_W
    t_offs[0] = 25'h1FFFFFF; t_offs[1] = 25'd2;
    t_dats[0] = 8'h5A;       t_dats[1] = 8'hC3;
    run_download(8'h01, 2, 1, 2, 2);

    // randomized downloads with sporadic back-pressure
    ack_mode = 1;
    for (int r = 0; r < 10; r++) begin
      int n;
      n = $urandom_range(0, 8);
      for (int i = 0; i < n; i++) begin
        t_offs[i] = 25'($urandom_range(0, 31));
        t_dats[i] = 8'($urandom);
      end
      run_download(idx_pool[$urandom_range(0, 5)], n, 1, 3, n);
    end
    ack_mode = 0;

    // full stall during a 6-byte burst: 4 bytes fit, 2 are dropped
    for (int i = 0; i < 6; i++) begin t_offs[i] = 25'(i); t_dats[i] = 8'($urandom); end
    ovf_exp  = 1'b1;
    ack_mode = 2;
    fork
      run_download(8'h01, 6, 0, 0, 4);
      begin
        repeat (10) @(posedge clk);
        #2;
        ack_mode = 0;
      end
    join

    // reset after the first pointer byte is accepted
    ptr0_seen = 1'b0;
    @(posedge clk);
    #1;
    ioctl_download = 1'b1;
    ioctl_index    = 8'h01;
    @(posedge clk);
    #1;
    ioctl_wr = 1'b1; ioctl_addr = 25'd0; ioctl_dout = 8'h77;
    exp_q.push_back({PRG_BASE, 8'h77});
    exp_q.push_back({PTR_ADDR, 8'h96});
    exp_q.push_back({PTR_ADDR + 25'd1, 8'h89});
    @(posedge clk);
    #1;
    ioctl_wr = 1'b0;
    ioctl_download = 1'b0;
    got = 1'b0;
    for (int c = 0; c < 100; c++) begin
      @(negedge clk);
      #1;
      if (ptr0_seen) begin got = 1'b1; break; end
    end
    check("ptr0_accepted", 33'(got), 33'd1);
    @(posedge clk);
    #2;
    reset_n = 1'b0;
    exp_q.delete();
    #1;
    check("rst_mem_wr", 33'(mem_wr), 33'd0);
    check("rst_downloading", 33'(downloading), 33'd0);
    check("rst_rom_done", 33'(rom_done), 33'd0);
    check("rst_overflow", 33'(overflow), 33'd0);
    check("rst_mem_bus", {mem_addr, mem_data}, 33'd0);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    repeat (20) @(negedge clk);
    check("post_rst_idle", 33'(state_dbg), 33'(ST_IDLE));
    check("post_rst_no_write", 33'(mem_wr), 33'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  // hang guard
  initial begin
    #3000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
